// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-back controller for the 16-entry register file.
// After reset it clears R1..R15 through the file's single write port. It then
// arbitrates ALU and LSU write-backs onto that port, and keeps a pending-write
// scoreboard that the issue stage uses to stall on RAW/WAW hazards.
// Build option: define REGFILE_WB_RR_EN for round-robin arbitration between
// ALU and LSU. Without it, the LSU always wins on contention.
module regfile_wb_ctrl #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [AW-1:0] lsu_addr,
  input  logic [DW-1:0] lsu_data,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_src1,
  input  logic [AW-1:0] iss_src2,
  input  logic [AW-1:0] iss_dst,
  output logic          hazard,
  output logic          rf_we,
  output logic [AW-1:0] rf_a3,
  output logic [DW-1:0] rf_wd,
  output logic          init_done
);

  localparam int NREG = 2 ** AW;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_init_cnt;
  logic [AW-1:0] w_init_cnt_next;
  logic          r_rf_we;
  logic          w_rf_we_next;
  logic [AW-1:0] r_rf_a3;
  logic [AW-1:0] w_rf_a3_next;
  logic [DW-1:0] r_rf_wd;
  logic [DW-1:0] w_rf_wd_next;
  logic          r_init_done;
  logic          w_init_done_next;

  logic          w_run;
  logic          w_grant_alu;
  logic          w_grant_lsu;
  logic          w_grant_any;
  logic [AW-1:0] w_wb_addr;
  logic [DW-1:0] w_wb_data;

  logic [NREG-1:0] w_busy;
  logic            w_haz_src1;
  logic            w_haz_src2;
  logic            w_haz_dst;
  logic            w_hazard;
  logic            w_issue_set;

  assign w_run = (r_state == ST_RUN);

`ifdef REGFILE_WB_RR_EN
  // Round-robin pointer: names the requester that wins the next contention.
  typedef enum logic {
    RR_ALU = 1'b0,
    RR_LSU = 1'b1
  } rr_t;

  rr_t r_rr_ptr;

  // Grant: a lone requester wins; on contention the pointer decides.
  always_comb begin
    w_grant_alu = w_run & alu_valid & (~lsu_valid | (r_rr_ptr == RR_ALU));
    w_grant_lsu = w_run & lsu_valid & (~alu_valid | (r_rr_ptr == RR_LSU));
  end

  // After any grant the pointer moves to the requester that was not granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr <= RR_ALU;
    end else if (w_grant_alu) begin
      r_rr_ptr <= RR_LSU;
    end else if (w_grant_lsu) begin
      r_rr_ptr <= RR_ALU;
    end
  end
`else
  // Grant: fixed priority, loads always win so the memory pipe never backs up.
  always_comb begin
    w_grant_lsu = w_run & lsu_valid;
    w_grant_alu = w_run & alu_valid & ~lsu_valid;
  end
`endif

  assign w_grant_any = w_grant_alu | w_grant_lsu;
  assign w_wb_addr   = w_grant_lsu ? lsu_addr : alu_addr;
  assign w_wb_data   = w_grant_lsu ? lsu_data : alu_data;

  // Hazard: any referenced register with a write in flight; R0 never stalls.
  // The whole init sequence stalls issue because the file is not yet valid.
  always_comb begin
    w_haz_src1  = (iss_src1 != '0) & w_busy[iss_src1];
    w_haz_src2  = (iss_src2 != '0) & w_busy[iss_src2];
    w_haz_dst   = (iss_dst  != '0) & w_busy[iss_dst];
    w_hazard    = ~w_run | w_haz_src1 | w_haz_src2 | w_haz_dst;
    w_issue_set = iss_valid & ~w_hazard & (iss_dst != '0);
  end

  // Scoreboard: one pending bit per register; R0 is never pending.
  // A new issue to a register overrides a write-back retiring the same register.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_r0
        assign w_busy[gi] = 1'b0;
      end else begin : g_rn
        logic r_busy_bit;
        logic w_set;
        logic w_clr;

        assign w_set = w_issue_set & (iss_dst == AW'(gi));
        assign w_clr = w_grant_any & (w_wb_addr == AW'(gi));

        // Per-register pending flag with set-over-clear priority.
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            r_busy_bit <= 1'b0;
          end else if (w_set) begin
            r_busy_bit <= 1'b1;
          end else if (w_clr) begin
            r_busy_bit <= 1'b0;
          end
        end

        assign w_busy[gi] = r_busy_bit;
      end
    end
  endgenerate

  // Next state and next write-port values. INIT walks R1..R15, then spends
  // one idle cycle (counter wrapped to 0) before entering RUN.
  always_comb begin
    w_state_next     = r_state;
    w_init_cnt_next  = r_init_cnt;
    w_rf_we_next     = 1'b0;
    w_rf_a3_next     = r_rf_a3;
    w_rf_wd_next     = r_rf_wd;
    w_init_done_next = r_init_done;
    case (r_state)
      ST_INIT: begin
        if (r_init_cnt != '0) begin
          w_rf_we_next    = 1'b1;
          w_rf_a3_next    = r_init_cnt;
          w_rf_wd_next    = '0;
          w_init_cnt_next = r_init_cnt + AW'(1);
        end else begin
          w_state_next     = ST_RUN;
          w_init_done_next = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_grant_any) begin
          // A write to R0 still completes its handshake but never reaches the file.
          w_rf_we_next = (w_wb_addr != '0);
          w_rf_a3_next = w_wb_addr;
          w_rf_wd_next = w_wb_data;
        end
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end

  // State and registered write-port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= AW'(1);
      r_rf_we     <= 1'b0;
      r_rf_a3     <= '0;
      r_rf_wd     <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_init_cnt  <= w_init_cnt_next;
      r_rf_we     <= w_rf_we_next;
      r_rf_a3     <= w_rf_a3_next;
      r_rf_wd     <= w_rf_wd_next;
      r_init_done <= w_init_done_next;
    end
  end

  assign alu_ready = w_grant_alu;
  assign lsu_ready = w_grant_lsu;
  assign hazard    = w_hazard;
  assign rf_we     = r_rf_we;
  assign rf_a3     = r_rf_a3;
  assign rf_wd     = r_rf_wd;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: table-driven directed vectors, hand-written reset/init
// sequences and randomized traffic, all checked against a behavioural model.
module tb_regfile_wb_ctrl;

  localparam int DW = 16;
  localparam int AW = 4;
`ifdef REGFILE_WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, alu_ready;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          lsu_valid, lsu_ready;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_data;
  logic          iss_valid;
  logic [AW-1:0] iss_src1, iss_src2, iss_dst;
  logic          hazard;
  logic          rf_we;
  logic [AW-1:0] rf_a3;
  logic [DW-1:0] rf_wd;
  logic          init_done;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_dst(iss_dst),
    .hazard(hazard), .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .init_done(init_done)
  );

  typedef struct packed {
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          lv;
    logic [AW-1:0] la;
    logic [DW-1:0] ld;
    logic          iv;
    logic [AW-1:0] s1;
    logic [AW-1:0] s2;
    logic [AW-1:0] dst;
  } stim_t;

  typedef struct {
    stim_t         s;
    logic          ar;
    logic          lr;
    logic          hz;
    logic          we;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd;
    logic          cd;   // compare rf_a3/rf_wd
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- behavioural model ----------------
  bit [15:0]     m_busy;
  bit            m_done;
  int            m_edges;
  bit            m_pref_alu;
  bit            m_we;
  logic [AW-1:0] m_a3;
  logic [DW-1:0] m_wd;
  bit            m_dknown;

  task automatic model_reset();
    m_busy = '0; m_done = 0; m_edges = 0; m_pref_alu = 1;
    m_we = 0; m_a3 = '0; m_wd = '0; m_dknown = 1;
  endtask

  task automatic m_comb(input stim_t s, output bit ga, output bit gl, output bit hz);
    ga = 0; gl = 0;
    if (!m_done) begin
      hz = 1;
    end else begin
      hz = (s.s1 != 0 && m_busy[s.s1]) || (s.s2 != 0 && m_busy[s.s2]) ||
           (s.dst != 0 && m_busy[s.dst]);
      if (s.av && s.lv) begin
        if (RR) begin ga = m_pref_alu; gl = !m_pref_alu; end
        else    begin ga = 0; gl = 1; end
      end else begin
        ga = s.av; gl = s.lv;
      end
    end
  endtask

  task automatic m_edge(input stim_t s, input bit ga, input bit gl, input bit hz);
    logic [AW-1:0] addr;
    if (!m_done) begin
      if (m_edges < 15) begin
        m_we = 1; m_a3 = AW'(m_edges + 1); m_wd = '0; m_dknown = 1;
      end else begin
        m_we = 0; m_done = 1;
      end
      m_edges++;
    end else begin
      m_we = 0;
      if (ga || gl) begin
        addr = gl ? s.la : s.aa;
        m_we = (addr != 0);
        m_a3 = addr;
        m_wd = gl ? s.ld : s.ad;
        m_dknown = (addr != 0);
        m_pref_alu = gl;
        if (addr != 0) m_busy[addr] = 0;
      end
      if (s.iv && !hz && s.dst != 0) m_busy[s.dst] = 1;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input stim_t s);
    alu_valid = s.av; alu_addr = s.aa; alu_data = s.ad;
    lsu_valid = s.lv; lsu_addr = s.la; lsu_data = s.ld;
    iss_valid = s.iv; iss_src1 = s.s1; iss_src2 = s.s2; iss_dst = s.dst;
  endtask

  function automatic stim_t mk(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                               input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                               input logic iv, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                               input logic [AW-1:0] dst);
    stim_t s;
    s.av = av; s.aa = aa; s.ad = ad; s.lv = lv; s.la = la; s.ld = ld;
    s.iv = iv; s.s1 = s1; s.s2 = s2; s.dst = dst;
    return s;
  endfunction

  // One clock: drive at negedge, check combinational outputs, then check
  // the registered outputs 1 time unit after the rising edge.
  task automatic run_cycle(input stim_t s, input string tag,
                           output logic o_ar, output logic o_lr, output logic o_hz,
                           output logic o_we, output logic [AW-1:0] o_a3, output logic [DW-1:0] o_wd);
    bit ga, gl, hz;
    @(negedge clk);
    apply(s);
    #1;
    m_comb(s, ga, gl, hz);
    o_ar = alu_ready; o_lr = lsu_ready; o_hz = hazard;
    check({tag, ":alu_ready"}, 32'(alu_ready), 32'(ga));
    check({tag, ":lsu_ready"}, 32'(lsu_ready), 32'(gl));
    check({tag, ":hazard"}, 32'(hazard), 32'(hz));
    @(posedge clk);
    m_edge(s, ga, gl, hz);
    #1;
    o_we = rf_we; o_a3 = rf_a3; o_wd = rf_wd;
    check({tag, ":rf_we"}, 32'(rf_we), 32'(m_we));
    check({tag, ":init_done"}, 32'(init_done), 32'(m_done));
    if (m_dknown) begin
      check({tag, ":rf_a3"}, 32'(rf_a3), 32'(m_a3));
      check({tag, ":rf_wd"}, 32'(rf_wd), 32'(m_wd));
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
  endtask

  vec_t tbl[16];

  task automatic setv(input int i, input stim_t s, input logic ar, input logic lr, input logic hz,
                      input logic we, input logic [AW-1:0] a3, input logic [DW-1:0] wd, input logic cd);
    tbl[i].s = s; tbl[i].ar = ar; tbl[i].lr = lr; tbl[i].hz = hz;
    tbl[i].we = we; tbl[i].a3 = a3; tbl[i].wd = wd; tbl[i].cd = cd;
  endtask

  // Bound on total run time.
  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t         idle;
    stim_t         both;
    stim_t         rs;
    logic          ar, lr, hz, we;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd;
    int            pulses;
    int            done_edge;

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    both = mk(1, 4'd2, 16'h1111, 1, 4'd5, 16'h5555, 0, 0, 0, 0);

    setv(0,  mk(1, 4'd3, 16'hBEEF, 0, 0, 0, 0, 0, 0, 0),          1, 0, 0, 1, 4'd3, 16'hBEEF, 1);
    setv(1,  idle,                                                0, 0, 0, 0, 4'd3, 16'hBEEF, 1);
    setv(2,  mk(0, 0, 0, 1, 4'd9, 16'h1234, 0, 0, 0, 0),          0, 1, 0, 1, 4'd9, 16'h1234, 1);
    setv(3,  both, RR, !RR, 0, 1, RR ? 4'd2 : 4'd5, RR ? 16'h1111 : 16'h5555, 1);
    setv(4,  both,                                                0, 1, 0, 1, 4'd5, 16'h5555, 1);
    setv(5,  both, RR, !RR, 0, 1, RR ? 4'd2 : 4'd5, RR ? 16'h1111 : 16'h5555, 1);
    setv(6,  both,                                                0, 1, 0, 1, 4'd5, 16'h5555, 1);
    setv(7,  mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'd7),                 0, 0, 0, 0, 4'd5, 16'h5555, 1);
    setv(8,  mk(0, 0, 0, 0, 0, 0, 1, 4'd7, 0, 0),                 0, 0, 1, 0, 4'd5, 16'h5555, 1);
    setv(9,  mk(0, 0, 0, 1, 4'd7, 16'h7777, 0, 4'd7, 0, 0),       0, 1, 1, 1, 4'd7, 16'h7777, 1);
    setv(10, mk(0, 0, 0, 0, 0, 0, 0, 4'd7, 0, 0),                 0, 0, 0, 0, 4'd7, 16'h7777, 1);
    setv(11, mk(0, 0, 0, 1, 4'd7, 16'h7070, 1, 0, 0, 4'd7),       0, 1, 0, 1, 4'd7, 16'h7070, 1);
    setv(12, mk(0, 0, 0, 0, 0, 0, 0, 4'd7, 0, 0),                 0, 0, 1, 0, 4'd7, 16'h7070, 1);
    setv(13, mk(0, 0, 0, 1, 4'd0, 16'hFFFF, 1, 0, 0, 0),          0, 1, 0, 0, 4'd0, 16'h0000, 0);
    setv(14, mk(0, 0, 0, 1, 4'd7, 16'h0000, 0, 0, 4'd7, 0),       0, 1, 1, 1, 4'd7, 16'h0000, 1);
    setv(15, mk(0, 0, 0, 0, 0, 0, 0, 0, 4'd7, 4'd7),              0, 0, 0, 0, 4'd7, 16'h0000, 1);

    // ---- reset state, requests held high while in reset ----
    rst = 1'b0;
    apply(mk(1, 4'd1, 16'hAAAA, 1, 4'd2, 16'h5555, 1, 0, 0, 4'd3));
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset:rf_we", 32'(rf_we), 32'd0);
    check("reset:rf_a3", 32'(rf_a3), 32'd0);
    check("reset:rf_wd", 32'(rf_wd), 32'd0);
    check("reset:init_done", 32'(init_done), 32'd0);
    check("reset:hazard", 32'(hazard), 32'd1);
    check("reset:alu_ready", 32'(alu_ready), 32'd0);
    check("reset:lsu_ready", 32'(lsu_ready), 32'd0);

    // ---- reset asserted mid-init at init_cnt=8 ----
    release_reset();
    for (int i = 0; i < 7; i++) run_cycle(idle, "init_pre", ar, lr, hz, we, a3, wd);
    check("midrst:pre_rf_a3", 32'(rf_a3), 32'd7);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst:rf_we", 32'(rf_we), 32'd0);
    check("midrst:init_done", 32'(init_done), 32'd0);
    check("midrst:rf_a3", 32'(rf_a3), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);

    // ---- full init sequence ----
    release_reset();
    pulses = 0;
    done_edge = 0;
    for (int e = 1; e <= 16; e++) begin
      run_cycle(idle, "init", ar, lr, hz, we, a3, wd);
      if (e == 1) check("init:first_a3", 32'(a3), 32'd1);
      if (we) pulses++;
      if (init_done && done_edge == 0) done_edge = e;
    end
    check("init:we_pulses", 32'(pulses), 32'd15);
    check("init:done_edge", 32'(done_edge), 32'd16);
    $display("init: %0d write pulses, init_done at edge %0d", pulses, done_edge);

    // ---- directed vectors ----
    for (int i = 0; i < 16; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      run_cycle(tbl[i].s, t, ar, lr, hz, we, a3, wd);
      check({t, ":tbl_alu_ready"}, 32'(ar), 32'(tbl[i].ar));
      check({t, ":tbl_lsu_ready"}, 32'(lr), 32'(tbl[i].lr));
      check({t, ":tbl_hazard"}, 32'(hz), 32'(tbl[i].hz));
      check({t, ":tbl_rf_we"}, 32'(we), 32'(tbl[i].we));
      if (tbl[i].cd) begin
        check({t, ":tbl_rf_a3"}, 32'(a3), 32'(tbl[i].a3));
        check({t, ":tbl_rf_wd"}, 32'(wd), 32'(tbl[i].wd));
      end
      $display("vec %0d: alu_ready=%0d lsu_ready=%0d hazard=%0d rf_we=%0d rf_a3=%0d rf_wd=%h",
               i, ar, lr, hz, we, a3, wd);
    end

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 2000; n++) begin
      rs.av  = ($urandom_range(0, 9) < 6);
      rs.aa  = AW'($urandom_range(0, 7));
      rs.ad  = DW'($urandom);
      rs.lv  = ($urandom_range(0, 9) < 5);
      rs.la  = AW'($urandom_range(0, 7));
      rs.ld  = DW'($urandom);
      rs.iv  = ($urandom_range(0, 1) == 1);
      rs.s1  = AW'($urandom_range(0, 7));
      rs.s2  = AW'($urandom_range(0, 7));
      rs.dst = AW'($urandom_range(0, 7));
      run_cycle(rs, "rand", ar, lr, hz, we, a3, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
